mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter XLEN, default 32, meaning data/address width; legal values are 32 and 64.
REQ-002 Parameter REG_ADDR_W, default 5, meaning destination register index width.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  is the reset: synchronous, active-high.
REQ-005 Upstream ports: in_valid in 1; in_ready out 1; rd in REG_ADDR_W; regwe in 1; wbdata in XLEN (ALU result or effective address); mem_re in 1; mem_we in 1; mem_size in 2 (00 byte, 01 half, 10 word, 11 dword); mem_unsigned in 1; store_data in XLEN.
REQ-006 Data-memory ports: dmem_req out 1; dmem_we out 1; dmem_addr out XLEN, word-aligned; dmem_wdata out XLEN; dmem_be out XLEN/8; dmem_ack in 1; dmem_rdata in XLEN.
REQ-007 Writeback ports: out_valid out 1; rd_o out REG_ADDR_W; regwe_o out 1; wbdata_o out XLEN; misalign_o out 1.

Function
REQ-008 The FSM SHALL have states IDLE and BUSY; in_ready SHALL be 1 exactly in IDLE.
REQ-009 An instruction is accepted on a rising edge with in_valid=1 and in_ready=1; in_valid=1 with mem_re=1 and mem_we=1 SHALL be treated as a store.
REQ-010 A non-memory instruction (mem_re=0, mem_we=0) SHALL appear on rd_o/regwe_o/wbdata_o with out_valid=1 in the cycle after acceptance (latency 1); the FSM stays in IDLE.
REQ-011 out_valid SHALL be a one-cycle pulse per accepted instruction; with no acceptance or completion it is 0 and rd_o/regwe_o/wbdata_o/misalign_o hold their values.
REQ-012 Misalignment: half with addr[0]!=0, word with addr[1:0]!=0, or dword with addr[2:0]!=0 SHALL be misaligned; mem_size=11 with XLEN=32 SHALL also be treated as misaligned.
REQ-013 A misaligned memory instruction SHALL issue no dmem request and SHALL complete next cycle with out_valid=1, misalign_o=1, regwe_o=0, rd_o=rd, wbdata_o=address.
REQ-014 An aligned memory instruction SHALL move the FSM to BUSY; dmem_req SHALL be 1 from the cycle after acceptance until and including the cycle dmem_ack=1.
REQ-015 While dmem_req=1, dmem_we, dmem_addr, dmem_wdata, and dmem_be SHALL be stable; dmem_addr = address with its low log2(XLEN/8) bits cleared.
REQ-016 Byte lanes are little-endian: lane offset = address modulo XLEN/8; dmem_be SHALL have 1, 2, 4, or 8 contiguous bits set, starting at the offset, for byte, half, word, or dword.
REQ-017 Store data SHALL be replicated/shifted so the low bytes of store_data occupy the enabled lanes of dmem_wdata; disabled lanes are don't-care.
REQ-018 dmem_ack SHALL be ignored in IDLE; an ack arriving in the same cycle dmem_req first rises is legal.
REQ-019 On the ack cycle the FSM SHALL return to IDLE, and the outputs SHALL update in the next cycle with out_valid=1 and misalign_o=0.
REQ-020 Load completion: regwe_o = the captured regwe; wbdata_o = selected lanes of dmem_rdata, shifted to bit 0, then sign-extended (mem_unsigned=0) or zero-extended (mem_unsigned=1) to XLEN.
REQ-021 Store completion: regwe_o=0; wbdata_o = address.
REQ-022 Minimum memory-op occupancy is 2 cycles (accept, req+ack); the next instruction can be accepted in the cycle after the ack.
REQ-023 All inputs needed for completion (rd, regwe, size, unsigned, offset, address) SHALL be captured at acceptance; upstream changes during BUSY have no effect.

Reset
REQ-024 While rst=1 at a clock edge, the block SHALL go to IDLE and set: out_valid=0, rd_o=0, regwe_o=0, wbdata_o=0, misalign_o=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_be=0.
REQ-025 A reset asserted in BUSY SHALL abandon the request; a dmem_ack for that request arriving after reset SHALL be ignored, producing no out_valid.
REQ-026 No instruction SHALL be accepted on an edge where rst=1.

Verification
REQ-027 Passthrough: ALU op with rd=5, regwe=1, wbdata=0x1234 -> next cycle out_valid=1, rd_o=5, regwe_o=1, wbdata_o=0x1234.
REQ-028 Signed byte load: addr 0x1003, dmem_rdata=0x80FF_FF7F returned after 3 wait cycles -> dmem_be=1000, dmem_addr=0x1000, wbdata_o=0xFFFF_FF80, in_ready=0 throughout BUSY.
REQ-029 Half store: addr 0x2002, store_data=0xAAAA_BEEF -> dmem_we=1, dmem_be=1100, dmem_wdata[31:16]=0xBEEF, regwe_o=0.
REQ-030 Misaligned word load at addr 0x3001 -> no dmem_req, misalign_o=1, regwe_o=0, wbdata_o=0x3001.
REQ-031 Same-cycle ack followed by back-to-back loads -> each completes with exactly one out_valid pulse and no lost or duplicated instruction.
REQ-032 rst pulsed during BUSY, then a late dmem_ack -> all outputs 0, FSM in IDLE, no out_valid.

Source files
------------

// File: rtl/mem_lsu.sv
// ---------------------------------------------------------------------------
// mem_lsu : load/store unit sitting between the execute stage and writeback.
//
// Accepts one instruction at a time from upstream. Non-memory instructions
// and misaligned memory instructions complete one cycle after acceptance.
// Aligned loads and stores issue a single request to the data memory, wait
// for its acknowledge, and complete one cycle after the acknowledge.
//
// Ports
//   clk, rst        : clock and synchronous active-high reset
//   in_valid        : upstream has an instruction
//   in_ready        : unit is idle and can take an instruction
//   rd, regwe       : destination register index and write enable
//   wbdata          : ALU result or effective address
//   mem_re, mem_we  : load / store request (both set is a store)
//   mem_size        : 00 byte, 01 half, 10 word, 11 dword
//   mem_unsigned    : zero-extend load data instead of sign-extending
//   store_data      : store data, low bytes significant
//   dmem_*          : data-memory request (word-aligned address, byte lanes)
//   out_valid       : one-cycle completion pulse
//   rd_o, regwe_o   : destination register index and write enable
//   wbdata_o        : writeback value (ALU result, load data or address)
//   misalign_o      : completed instruction was a misaligned memory access
// ---------------------------------------------------------------------------
module mem_lsu #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  regwe,
  input  logic [XLEN-1:0]       wbdata,
  input  logic                  mem_re,
  input  logic                  mem_we,
  input  logic [1:0]            mem_size,
  input  logic                  mem_unsigned,
  input  logic [XLEN-1:0]       store_data,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [XLEN-1:0]       dmem_addr,
  output logic [XLEN-1:0]       dmem_wdata,
  output logic [XLEN/8-1:0]     dmem_be,
  input  logic                  dmem_ack,
  input  logic [XLEN-1:0]       dmem_rdata,
  output logic                  out_valid,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic                  regwe_o,
  output logic [XLEN-1:0]       wbdata_o,
  output logic                  misalign_o
);

  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);

  localparam logic [XLEN-1:0] MASK_B = XLEN'(64'h0000_0000_0000_00FF);
  localparam logic [XLEN-1:0] MASK_H = XLEN'(64'h0000_0000_0000_FFFF);
  localparam logic [XLEN-1:0] MASK_W = XLEN'(64'h0000_0000_FFFF_FFFF);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic                  w_accept;
  logic                  w_isMem;
  logic                  w_isStore;
  logic                  w_misalign;
  logic [OFF_W-1:0]      w_offset;
  logic [7:0]            w_beByte;
  logic [BE_W-1:0]       w_be;
  logic [XLEN-1:0]       w_wdata;
  logic [XLEN-1:0]       w_lineAddr;

  logic [XLEN-1:0]       w_loadShift;
  logic [XLEN-1:0]       w_loadMask;
  logic                  w_loadSign;
  logic [XLEN-1:0]       w_loadData;

  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_regwe;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [OFF_W-1:0]      r_offset;
  logic [XLEN-1:0]       r_addr;
  logic                  r_isStore;

  assign in_ready  = (r_state == IDLE);
  assign w_accept  = in_valid && (r_state == IDLE);
  assign w_isMem   = mem_re || mem_we;
  assign w_isStore = mem_we;
  assign w_offset  = wbdata[OFF_W-1:0];
  assign w_lineAddr = {wbdata[XLEN-1:OFF_W], {OFF_W{1'b0}}};

  // Alignment check on the incoming address. A dword access cannot be
  // served on a 32-bit bus, so it is always reported as misaligned there.
  always_comb begin
    w_misalign = 1'b0;
    case (mem_size)
      2'b00:   w_misalign = 1'b0;
      2'b01:   w_misalign = wbdata[0];
      2'b10:   w_misalign = |wbdata[1:0];
      default: w_misalign = (XLEN == 32) ? 1'b1 : |wbdata[2:0];
    endcase
  end

  // Byte enables start as a contiguous run at lane 0 and are moved up to
  // the lane offset. Store data is replicated across the bus so that the
  // low bytes land in whichever lanes end up enabled, which avoids a
  // separate data shifter.
  always_comb begin
    w_beByte = 8'h01;
    w_wdata  = store_data;
    case (mem_size)
      2'b00: begin
        w_beByte = 8'h01;
        w_wdata  = {(XLEN/8){store_data[7:0]}};
      end
      2'b01: begin
        w_beByte = 8'h03;
        w_wdata  = {(XLEN/16){store_data[15:0]}};
      end
      2'b10: begin
        w_beByte = 8'h0F;
        w_wdata  = {(XLEN/32){store_data[31:0]}};
      end
      default: begin
        w_beByte = 8'hFF;
        w_wdata  = store_data;
      end
    endcase
    w_be = w_beByte[BE_W-1:0] << w_offset;
  end

  // Load data path: bring the addressed lanes down to bit 0, keep the
  // access width, then fill the upper bits with either the sign bit of the
  // access or zeros. Everything here uses the values captured at acceptance.
  always_comb begin
    w_loadShift = dmem_rdata >> {r_offset, 3'b000};
    w_loadMask  = {XLEN{1'b1}};
    w_loadSign  = 1'b0;
    case (r_size)
      2'b00: begin
        w_loadMask = MASK_B;
        w_loadSign = w_loadShift[7];
      end
      2'b01: begin
        w_loadMask = MASK_H;
        w_loadSign = w_loadShift[15];
      end
      2'b10: begin
        w_loadMask = MASK_W;
        w_loadSign = w_loadShift[31];
      end
      default: begin
        w_loadMask = {XLEN{1'b1}};
        w_loadSign = 1'b0;
      end
    endcase
    w_loadData = (w_loadShift & w_loadMask)
               | ((w_loadSign && !r_unsigned) ? ~w_loadMask : {XLEN{1'b0}});
  end

  // State register. Reset drops any outstanding request, so an acknowledge
  // that arrives afterwards lands in IDLE and is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: only an aligned memory instruction leaves IDLE, and
  // the acknowledge is the only way back.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && w_isMem && !w_misalign) begin
          w_nextState = BUSY;
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Registered outputs and the per-instruction capture. out_valid defaults
  // low every cycle so it can only ever be a single-cycle pulse; the other
  // writeback outputs hold until the next completion. The request fields
  // are written only at acceptance, so they stay stable while dmem_req is up.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      rd_o       <= '0;
      regwe_o    <= 1'b0;
      wbdata_o   <= '0;
      misalign_o <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      r_rd       <= '0;
      r_regwe    <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_offset   <= '0;
      r_addr     <= '0;
      r_isStore  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (!w_isMem) begin
              out_valid  <= 1'b1;
              rd_o       <= rd;
              regwe_o    <= regwe;
              wbdata_o   <= wbdata;
              misalign_o <= 1'b0;
            end else if (w_misalign) begin
              out_valid  <= 1'b1;
              rd_o       <= rd;
              regwe_o    <= 1'b0;
              wbdata_o   <= wbdata;
              misalign_o <= 1'b1;
            end else begin
              dmem_req   <= 1'b1;
              dmem_we    <= w_isStore;
              dmem_addr  <= w_lineAddr;
              dmem_wdata <= w_wdata;
              dmem_be    <= w_be;
              r_rd       <= rd;
              r_regwe    <= regwe;
              r_size     <= mem_size;
              r_unsigned <= mem_unsigned;
              r_offset   <= w_offset;
              r_addr     <= wbdata;
              r_isStore  <= w_isStore;
            end
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            dmem_req   <= 1'b0;
            out_valid  <= 1'b1;
            rd_o       <= r_rd;
            misalign_o <= 1'b0;
            if (r_isStore) begin
              regwe_o  <= 1'b0;
              wbdata_o <= r_addr;
            end else begin
              regwe_o  <= r_regwe;
              wbdata_o <= w_loadData;
            end
          end
        end
        default: begin
          dmem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// ---------------------------------------------------------------------------
// tb_mem_lsu : directed testbench for mem_lsu (XLEN=32).
// Inputs change 1 time unit after the rising edge; outputs are checked at the
// same point, which is well clear of the active edge.
// ---------------------------------------------------------------------------
module tb_mem_lsu;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [REG_ADDR_W-1:0] rd;
  logic                  regwe;
  logic [XLEN-1:0]       wbdata;
  logic                  mem_re;
  logic                  mem_we;
  logic [1:0]            mem_size;
  logic                  mem_unsigned;
  logic [XLEN-1:0]       store_data;
  logic                  dmem_req;
  logic                  dmem_we;
  logic [XLEN-1:0]       dmem_addr;
  logic [XLEN-1:0]       dmem_wdata;
  logic [XLEN/8-1:0]     dmem_be;
  logic                  dmem_ack;
  logic [XLEN-1:0]       dmem_rdata;
  logic                  out_valid;
  logic [REG_ADDR_W-1:0] rd_o;
  logic                  regwe_o;
  logic [XLEN-1:0]       wbdata_o;
  logic                  misalign_o;

  int total = 0;
  int bad   = 0;

  mem_lsu #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .rd           (rd),
    .regwe        (regwe),
    .wbdata       (wbdata),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .store_data   (store_data),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_be      (dmem_be),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .out_valid    (out_valid),
    .rd_o         (rd_o),
    .regwe_o      (regwe_o),
    .wbdata_o     (wbdata_o),
    .misalign_o   (misalign_o)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one upstream instruction onto the inputs.
  task automatic applyStimulus(input logic v, input logic [4:0] r, input logic we_reg,
                               input logic [31:0] data, input logic re, input logic we,
                               input logic [1:0] size, input logic uns,
                               input logic [31:0] sdata);
    in_valid     = v;
    rd           = r;
    regwe        = we_reg;
    wbdata       = data;
    mem_re       = re;
    mem_we       = we;
    mem_size     = size;
    mem_unsigned = uns;
    store_data   = sdata;
  endtask

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 2'b00, 0, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_rd_o", 64'(rd_o), 64'd0);
    checkOutput("rst_wbdata_o", 64'(wbdata_o), 64'd0);
    checkOutput("rst_dmem_req", 64'(dmem_req), 64'd0);
    checkOutput("rst_dmem_be", 64'(dmem_be), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

    // Passthrough ALU op
    applyStimulus(1, 5'd5, 1, 32'h1234, 0, 0, 2'b10, 0, 32'h0);
    tick();
    applyStimulus(0, 5'd0, 0, 32'h0, 0, 0, 2'b00, 0, 32'h0);
    checkOutput("pt_out_valid", 64'(out_valid), 64'd1);
    checkOutput("pt_rd_o", 64'(rd_o), 64'd5);
    checkOutput("pt_regwe_o", 64'(regwe_o), 64'd1);
    checkOutput("pt_wbdata_o", 64'(wbdata_o), 64'h1234);
    checkOutput("pt_no_req", 64'(dmem_req), 64'd0);
    tick();
    checkOutput("pt_pulse_end", 64'(out_valid), 64'd0);
    checkOutput("pt_hold_wbdata", 64'(wbdata_o), 64'h1234);

    // Signed byte load at 0x1003, ack after three wait cycles
    applyStimulus(1, 5'd7, 1, 32'h1003, 1, 0, 2'b00, 0, 32'h0);
    tick();
    applyStimulus(0, 5'd31, 0, 32'hFFFF_FFFF, 0, 1, 2'b11, 1, 32'h0);
    checkOutput("lb_dmem_be", 64'(dmem_be), 64'b1000);
    checkOutput("lb_dmem_addr", 64'(dmem_addr), 64'h1000);
    checkOutput("lb_dmem_we", 64'(dmem_we), 64'd0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("lb_wait%0d_req", i), 64'(dmem_req), 64'd1);
      checkOutput($sformatf("lb_wait%0d_in_ready", i), 64'(in_ready), 64'd0);
      checkOutput($sformatf("lb_wait%0d_out_valid", i), 64'(out_valid), 64'd0);
      tick();
    end
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h80FF_FF7F;
    checkOutput("lb_ack_req", 64'(dmem_req), 64'd1);
    checkOutput("lb_ack_in_ready", 64'(in_ready), 64'd0);
    tick();
    dmem_ack = 1'b0;
    checkOutput("lb_out_valid", 64'(out_valid), 64'd1);
    checkOutput("lb_wbdata_o", 64'(wbdata_o), 64'hFFFF_FF80);
    checkOutput("lb_rd_o", 64'(rd_o), 64'd7);
    checkOutput("lb_regwe_o", 64'(regwe_o), 64'd1);
    checkOutput("lb_misalign_o", 64'(misalign_o), 64'd0);
    checkOutput("lb_req_drop", 64'(dmem_req), 64'd0);
    checkOutput("lb_in_ready", 64'(in_ready), 64'd1);

    // Half store at 0x2002, acknowledged in the first request cycle
    applyStimulus(1, 5'd3, 1, 32'h2002, 0, 1, 2'b01, 0, 32'hAAAA_BEEF);
    tick();
    applyStimulus(0, 5'd0, 0, 32'h0, 0, 0, 2'b00, 0, 32'h0);
    checkOutput("sh_dmem_req", 64'(dmem_req), 64'd1);
    checkOutput("sh_dmem_we", 64'(dmem_we), 64'd1);
    checkOutput("sh_dmem_be", 64'(dmem_be), 64'b1100);
    checkOutput("sh_dmem_addr", 64'(dmem_addr), 64'h2000);
    checkOutput("sh_wdata_hi", 64'(dmem_wdata[31:16]), 64'hBEEF);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    checkOutput("sh_out_valid", 64'(out_valid), 64'd1);
    checkOutput("sh_regwe_o", 64'(regwe_o), 64'd0);
    checkOutput("sh_wbdata_o", 64'(wbdata_o), 64'h2002);
    checkOutput("sh_rd_o", 64'(rd_o), 64'd3);
    tick();
    checkOutput("sh_pulse_end", 64'(out_valid), 64'd0);

    // Byte store at 0x8001: one lane, data replicated into it
    applyStimulus(1, 5'd4, 0, 32'h8001, 0, 1, 2'b00, 0, 32'h1234_565A);
    tick();
    applyStimulus(0, 5'd0, 0, 32'h0, 0, 0, 2'b00, 0, 32'h0);
    checkOutput("sb_dmem_be", 64'(dmem_be), 64'b0010);
    checkOutput("sb_wdata_lane1", 64'(dmem_wdata[15:8]), 64'h5A);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    checkOutput("sb_out_valid", 64'(out_valid), 64'd1);

    // Misaligned word load at 0x3001
    applyStimulus(1, 5'd9, 1, 32'h3001, 1, 0, 2'b10, 0, 32'h0);
    tick();
    applyStimulus(0, 5'd0, 0, 32'h0, 0, 0, 2'b00, 0, 32'h0);
    checkOutput("mis_no_req", 64'(dmem_req), 64'd0);
    checkOutput("mis_out_valid", 64'(out_valid), 64'd1);
    checkOutput("mis_misalign_o", 64'(misalign_o), 64'd1);
    checkOutput("mis_regwe_o", 64'(regwe_o), 64'd0);
    checkOutput("mis_wbdata_o", 64'(wbdata_o), 64'h3001);
    checkOutput("mis_rd_o", 64'(rd_o), 64'd9);
    checkOutput("mis_in_ready", 64'(in_ready), 64'd1);

    // Dword access on a 32-bit bus is misaligned even when address is aligned
    applyStimulus(1, 5'd2, 1, 32'h4000, 1, 0, 2'b11, 0, 32'h0);
    tick();
    applyStimulus(0, 5'd0, 0, 32'h0, 0, 0, 2'b00, 0, 32'h0);
    checkOutput("dw_misalign_o", 64'(misalign_o), 64'd1);
    checkOutput("dw_no_req", 64'(dmem_req), 64'd0);

    // Back-to-back loads, first one acknowledged in its first request cycle.
    // The second load is held on the inputs while the first is busy.
    applyStimulus(1, 5'd10, 1, 32'h5002, 1, 0, 2'b01, 1, 32'h0);
    tick();
    applyStimulus(1, 5'd11, 1, 32'h6000, 1, 0, 2'b10, 0, 32'h0);
    checkOutput("b2b_a_req", 64'(dmem_req), 64'd1);
    checkOutput("b2b_a_addr", 64'(dmem_addr), 64'h5000);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h8001_1234;
    tick();
    dmem_ack = 1'b0;
    checkOutput("b2b_a_out_valid", 64'(out_valid), 64'd1);
    checkOutput("b2b_a_wbdata_o", 64'(wbdata_o), 64'h0000_8001);
    checkOutput("b2b_a_rd_o", 64'(rd_o), 64'd10);
    checkOutput("b2b_a_in_ready", 64'(in_ready), 64'd1);
    tick();
    applyStimulus(0, 5'd0, 0, 32'h0, 0, 0, 2'b00, 0, 32'h0);
    checkOutput("b2b_b_no_pulse", 64'(out_valid), 64'd0);
    checkOutput("b2b_b_req", 64'(dmem_req), 64'd1);
    checkOutput("b2b_b_addr", 64'(dmem_addr), 64'h6000);
    checkOutput("b2b_b_be", 64'(dmem_be), 64'b1111);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    tick();
    dmem_ack = 1'b0;
    checkOutput("b2b_b_out_valid", 64'(out_valid), 64'd1);
    checkOutput("b2b_b_wbdata_o", 64'(wbdata_o), 64'hDEAD_BEEF);
    checkOutput("b2b_b_rd_o", 64'(rd_o), 64'd11);
    tick();
    checkOutput("b2b_done_no_pulse", 64'(out_valid), 64'd0);
    checkOutput("b2b_done_no_req", 64'(dmem_req), 64'd0);

    // Reset while busy, then a late acknowledge
    applyStimulus(1, 5'd12, 1, 32'h7000, 1, 0, 2'b10, 0, 32'h0);
    tick();
    applyStimulus(0, 5'd0, 0, 32'h0, 0, 0, 2'b00, 0, 32'h0);
    checkOutput("rb_req_before", 64'(dmem_req), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rb_dmem_req", 64'(dmem_req), 64'd0);
    checkOutput("rb_dmem_addr", 64'(dmem_addr), 64'd0);
    checkOutput("rb_wbdata_o", 64'(wbdata_o), 64'd0);
    checkOutput("rb_rd_o", 64'(rd_o), 64'd0);
    checkOutput("rb_in_ready", 64'(in_ready), 64'd1);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h1111_1111;
    tick();
    dmem_ack = 1'b0;
    checkOutput("rb_late_ack_no_valid", 64'(out_valid), 64'd0);
    checkOutput("rb_late_ack_wbdata", 64'(wbdata_o), 64'd0);
    checkOutput("rb_late_ack_in_ready", 64'(in_ready), 64'd1);

    // No acceptance on an edge where reset is high
    rst = 1'b1;
    applyStimulus(1, 5'd6, 1, 32'h5555, 0, 0, 2'b00, 0, 32'h0);
    tick();
    rst = 1'b0;
    applyStimulus(0, 5'd0, 0, 32'h0, 0, 0, 2'b00, 0, 32'h0);
    checkOutput("ra_no_valid", 64'(out_valid), 64'd0);
    tick();
    checkOutput("ra_still_no_valid", 64'(out_valid), 64'd0);
    checkOutput("ra_wbdata", 64'(wbdata_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
